mux_sel_rr_arbiter: RTL and testbench
=====================================

Name: mux_sel_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-bit resource between four requesters.
- Drives the 2-bit select of the shared 4:1 mux: sel = 0..3 chooses requester A..D.
- Registered, one-hot grant; a grant is held while the owner keeps requesting, bounded by a hold limit.
- Sits between the four requesting units (e.g. fetch, load/store, debug, DMA) and the shared memory/bus port.

Parameters:
- MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while another requester waits; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i (0=A, 1=B, 2=C, 3=D); level-sensitive.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  mux select, registered; equals index of the granted requester.
- busy  output  1  high while any grant is active (gnt != 0).
- owner_id  output  2  index of last/current owner; same as sel, provided for trace/debug.

Behaviour:
- Reset (reset=1 at a rising edge): gnt=0, sel=0, owner_id=0, busy=0, rr pointer ptr=0, hold counter cnt=0, state=IDLE. Reset overrides all other activity, including a grant in progress; gnt drops on the first edge with reset=1.
- State machine, two states:
  - IDLE.
  - GRANT (holds owner index o).
- Round-robin pick: search req starting at index ptr, ascending, mod 4; the first set bit wins. ptr is set to (winner+1) mod 4 whenever a new grant is issued.
- IDLE transitions:
  - req==0: stay IDLE; gnt=0; sel/owner_id hold their last value, so the mux output does not glitch.
  - req!=0 at edge n: go to GRANT with o=pick; gnt=onehot(o), sel=o, busy=1, cnt=0, all from edge n.
  - Latency from req to gnt is 1 cycle.
- GRANT transitions, evaluated each edge; the first matching rule applies:
  1. req[o]==0 and other req bits set: hand over directly to pick(req) with no idle cycle; cnt=0.
  2. req[o]==0 and req==0: go to IDLE; gnt=0, busy=0.
  3. req[o]==1, others pending, cnt==MAX_HOLD-1: forced rotation; grant pick(req with bit o masked); cnt=0.
  4. req[o]==1, others pending, cnt<MAX_HOLD-1: keep the grant; cnt=cnt+1.
  5. req[o]==1, no others pending: keep the grant; cnt stays 0. Hold time counts only while someone is waiting.
- Invariants:
  - gnt is always zero or one-hot.
  - sel==owner_id always.
  - When busy=1, sel equals the index of the set gnt bit.
  - No combinational path from req to any output.
- The owner is expected to drop req in the cycle after its last transfer. A requester whose grant is forcibly removed keeps req high and re-arbitrates normally; it has lowest priority because of ptr.
- Simultaneous events:
  - Owner drop coinciding with the hold limit is handled by rule 1; the pick starts from ptr, which is already past o.
  - New requests arriving in the same cycle as a handover take part in that pick.
- Starvation bound: a continuously requesting unit is granted within 3*MAX_HOLD+3 cycles.
- Implementation: ptr, cnt and state are all registered. sel/owner_id do not change in IDLE.

Test Plan:
1. Reset behaviour: reset=1 for 2 cycles with req=4'b1111 -> gnt=0, sel=0, busy=0. Release reset, req=4'b1111 -> next edge gnt=4'b0001, sel=0.
2. Round-robin handover: req=4'b1010, each owner drops its bit after 1 granted cycle and re-raises it 1 cycle later -> grant order B(1), D(3), B(1), D(3). Each handover takes effect on the edge after the owner drops req, with no gnt=0 cycle in between.
3. Hold limit, MAX_HOLD=8: A holds req[0]=1 from t0 with gnt=0001; C raises req[2] at t0 -> gnt stays 0001 for 8 cycles, then becomes 0100 with sel=2. A re-wins only after C releases.
4. Uncontested hold: only req[3]=1 for 50 cycles -> gnt=1000 for all 50 cycles, cnt stays 0, no rotation. After req drops to 0 -> gnt=0, busy=0, sel stays 3.
5. Reset mid-grant: B granted, reset=1 for 1 cycle -> gnt=0 on that edge, ptr=0. Then req=4'b0110 -> B(1) granted first (ptr=0 search: 0 no, 1 yes).
6. Random stress, 10k cycles: random req vector -> gnt is always zero/one-hot, sel matches gnt, no grant without its req bit set the previous cycle (except during hold of owner), and the starvation bound holds.

Source files
------------

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one resource through a 4:1 mux.
// Grants are registered and one-hot; an owner may hold the grant, bounded by MAX_HOLD while others wait.
module mux_sel_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic [1:0] owner_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [1:0]         sel_nxt;
    logic [3:0]         gnt_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         others;
    logic [1:0]         win_all;
    logic [1:0]         win_others;

    // First set bit of r searching upward from p, wrapping mod 4; caller guarantees r != 0.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        sel_nxt    = sel;
        ptr_nxt    = ptr;
        cnt_nxt    = cnt;
        others     = req & ~(4'b0001 << sel);
        win_all    = pick(req, ptr);
        win_others = pick(others, ptr);

        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << win_all;
                    sel_nxt   = win_all;
                    ptr_nxt   = win_all + 2'd1;
                    cnt_nxt   = '0;
                end else begin
                    gnt_nxt   = 4'b0000;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    cnt_nxt = '0;
                    if (others != 4'b0000) begin
                        gnt_nxt = 4'b0001 << win_all;
                        sel_nxt = win_all;
                        ptr_nxt = win_all + 2'd1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                    end
                end else if (others != 4'b0000) begin
                    // Hold time only accumulates while somebody else is waiting.
                    if (cnt == CNT_W'(MAX_HOLD - 1)) begin
                        gnt_nxt = 4'b0001 << win_others;
                        sel_nxt = win_others;
                        ptr_nxt = win_others + 2'd1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy     = |gnt;
    assign owner_id = sel;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed-vector bench for mux_sel_rr_arbiter with hand-computed expectations,
// followed by a random phase that checks grant invariants and the starvation bound.
module tb_mux_sel_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int STARVE   = 3 * MAX_HOLD + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [1:0] owner_id;

    int vectors = 0;
    int miscompares = 0;

    mux_sel_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .owner_id (owner_id)
    );

    always #5 clk = ~clk;

    // Drive inputs mid-cycle, then let one rising edge pass and settle before sampling.
    task automatic applyStimulus(input logic [3:0] r, input logic rst);
        @(negedge clk);
        req   = r;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkGrant(input string tag, input logic [3:0] eg, input logic [1:0] es);
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(eg));
        checkOutput({tag, ".sel"}, 32'(sel), 32'(es));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(eg != 4'b0000));
        checkOutput({tag, ".owner"}, 32'(owner_id), 32'(es));
    endtask

    initial begin
        int wait_cnt [4];

        // Reset with every requester active.
        applyStimulus(4'b1111, 1'b1);
        checkGrant("rst0", 4'b0000, 2'd0);
        applyStimulus(4'b1111, 1'b1);
        checkGrant("rst1", 4'b0000, 2'd0);
        applyStimulus(4'b1111, 1'b0);
        checkGrant("first", 4'b0001, 2'd0);
        applyStimulus(4'b0000, 1'b0);
        checkGrant("idle0", 4'b0000, 2'd0);

        // Round-robin handover between B and D with no idle gap; ptr=1 at start.
        applyStimulus(4'b1010, 1'b0);
        checkGrant("rr.B0", 4'b0010, 2'd1);
        applyStimulus(4'b1000, 1'b0);
        checkGrant("rr.D0", 4'b1000, 2'd3);
        applyStimulus(4'b0010, 1'b0);
        checkGrant("rr.B1", 4'b0010, 2'd1);
        applyStimulus(4'b1000, 1'b0);
        checkGrant("rr.D1", 4'b1000, 2'd3);
        applyStimulus(4'b0000, 1'b0);
        checkGrant("rr.idle", 4'b0000, 2'd3);

        // Hold limit: A keeps the grant for 8 cycles while C waits, then C is forced in.
        applyStimulus(4'b0001, 1'b0);
        checkGrant("hold.A", 4'b0001, 2'd0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            applyStimulus(4'b0101, 1'b0);
            checkGrant("hold.keepA", 4'b0001, 2'd0);
        end
        applyStimulus(4'b0101, 1'b0);
        checkGrant("hold.rotC", 4'b0100, 2'd2);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0101, 1'b0);
            checkGrant("hold.keepC", 4'b0100, 2'd2);
        end
        applyStimulus(4'b0001, 1'b0);
        checkGrant("hold.backA", 4'b0001, 2'd0);
        applyStimulus(4'b0000, 1'b0);
        checkGrant("hold.idle", 4'b0000, 2'd0);

        // Uncontested hold by D; idle afterwards keeps sel at 3.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(4'b1000, 1'b0);
            checkGrant("solo.D", 4'b1000, 2'd3);
        end
        applyStimulus(4'b0000, 1'b0);
        checkGrant("solo.idle", 4'b0000, 2'd3);

        // A long uncontested stretch must not pre-charge the hold counter.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b1000, 1'b0);
            checkGrant("solo2.D", 4'b1000, 2'd3);
        end
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            applyStimulus(4'b1001, 1'b0);
            checkGrant("solo2.keepD", 4'b1000, 2'd3);
        end
        applyStimulus(4'b1001, 1'b0);
        checkGrant("solo2.rotA", 4'b0001, 2'd0);

        // Reset in the middle of B's grant restores ptr to 0.
        applyStimulus(4'b0010, 1'b0);
        checkGrant("mid.B", 4'b0010, 2'd1);
        applyStimulus(4'b0010, 1'b1);
        checkGrant("mid.rst", 4'b0000, 2'd0);
        applyStimulus(4'b0110, 1'b0);
        checkGrant("mid.B2", 4'b0010, 2'd1);
        applyStimulus(4'b0000, 1'b0);
        checkGrant("mid.idle", 4'b0000, 2'd1);

        // Random phase: invariants plus the starvation bound.
        for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            applyStimulus(r, 1'b0);
            checkOutput("rnd.onehot", 32'($onehot0(gnt)), 32'd1);
            checkOutput("rnd.noreq", 32'(gnt & ~r), 32'd0);
            checkOutput("rnd.busy", 32'(busy), 32'(r != 4'b0000));
            checkOutput("rnd.owner", 32'(owner_id), 32'(sel));
            if (busy) checkOutput("rnd.selgnt", 32'(gnt), 32'(4'b0001 << sel));
            for (int k = 0; k < 4; k++) begin
                if (r[k] && !gnt[k]) wait_cnt[k]++;
                else wait_cnt[k] = 0;
                if (wait_cnt[k] > STARVE) begin
                    checkOutput("rnd.starve", 32'(wait_cnt[k]), 32'(STARVE));
                    wait_cnt[k] = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
